// File: rtl/debug_snapshot_streamer_if.sv
// Handshake bundle between the snapshot streamer and the host transport.
// master: the streamer (accepts requests, produces frame words).
// slave:  the host (issues requests, consumes frame words).
interface debug_snapshot_streamer_if;
    logic        reqValid;
    logic        reqReady;
    logic        outValid;
    logic        outReady;
    logic [31:0] outData;
    logic        outLast;

    modport master (
        input  reqValid,
        output reqReady,
        output outValid,
        input  outReady,
        output outData,
        output outLast
    );

    modport slave (
        output reqValid,
        input  reqReady,
        input  outValid,
        output outReady,
        input  outData,
        input  outLast
    );
endinterface

// File: rtl/debug_snapshot_streamer.sv
// Debug snapshot streamer: captures PC, queue occupancies and performance
// counters atomically on a host request, then streams them as a framed
// sequence of 32-bit words over a valid/ready stream.
// Optional macro RSD_DEBUG_STREAM_CHECKSUM_EN appends an XOR checksum word.
module debug_snapshot_streamer #(
    parameter int PC_WIDTH         = 32,
    parameter int AL_COUNT_WIDTH   = 7,
    parameter int SQ_COUNT_WIDTH   = 5,
    parameter int PERF_COUNTER_NUM = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [PC_WIDTH-1:0]           lastCommittedPC,
    input  logic [AL_COUNT_WIDTH-1:0]     activeListCount,
    input  logic [SQ_COUNT_WIDTH-1:0]     storeQueueCount,
    input  logic [32*PERF_COUNTER_NUM-1:0] perfCounter,
    debug_snapshot_streamer_if.master     bus,
    output logic                          busy
);

`ifdef RSD_DEBUG_STREAM_CHECKSUM_EN
    localparam int LEN = 4 + PERF_COUNTER_NUM;
`else
    localparam int LEN = 3 + PERF_COUNTER_NUM;
`endif

    typedef enum logic {IDLE, SEND} state_t;

    state_t                         state;
    logic                           reqReadyR;
    logic                           validR;
    logic [31:0]                    dataR;
    logic                           lastR;
    logic                           busyR;
    logic [7:0]                     seqR;
    logic [7:0]                     index;
    logic [PC_WIDTH-1:0]            pcR;
    logic [AL_COUNT_WIDTH-1:0]      alR;
    logic [SQ_COUNT_WIDTH-1:0]      sqR;
    logic [32*PERF_COUNTER_NUM-1:0] perfR;

    logic        accept;
    logic        xfer;
    logic [7:0]  nextIdx;
    logic [31:0] nextWord;

    assign accept = (state == IDLE) && reqReadyR && bus.reqValid;
    assign xfer   = (state == SEND) && bus.outReady;

    assign bus.reqReady = reqReadyR;
    assign bus.outValid = validR;
    assign bus.outData  = dataR;
    assign bus.outLast  = lastR;
    assign busy         = busyR;

`ifdef RSD_DEBUG_STREAM_CHECKSUM_EN
    logic [31:0] csum;

    // Running XOR of transferred words, restarted at every accepted request.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            csum <= '0;
        end else if (accept) begin
            csum <= '0;
        end else if (xfer) begin
            csum <= csum ^ dataR;
        end
    end
`endif

    // Word that follows the one currently presented, taken from the snapshot.
    always_comb begin
        nextIdx  = index + 8'd1;
        nextWord = '0;
        if (nextIdx == 8'd1) begin
            nextWord = 32'(pcR);
        end else if (nextIdx == 8'd2) begin
            nextWord = {16'(sqR), 16'(alR)};
`ifdef RSD_DEBUG_STREAM_CHECKSUM_EN
        end else if (nextIdx == 8'(LEN - 1)) begin
            nextWord = csum ^ dataR;
`endif
        end else if (nextIdx >= 8'd3 && int'(nextIdx) < 3 + PERF_COUNTER_NUM) begin
            nextWord = perfR[32*(int'(nextIdx) - 3) +: 32];
        end
    end

    // Request/frame sequencer; all stream outputs are registered here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            reqReadyR <= 1'b0;
            validR    <= 1'b0;
            dataR     <= '0;
            lastR     <= 1'b0;
            busyR     <= 1'b0;
            seqR      <= '0;
            index     <= '0;
            pcR       <= '0;
            alR       <= '0;
            sqR       <= '0;
            perfR     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    reqReadyR <= 1'b1;
                    if (accept) begin
                        pcR       <= lastCommittedPC;
                        alR       <= activeListCount;
                        sqR       <= storeQueueCount;
                        perfR     <= perfCounter;
                        index     <= '0;
                        dataR     <= {8'hD5, seqR, 8'(LEN), 8'h00};
                        validR    <= 1'b1;
                        lastR     <= 1'b0;
                        busyR     <= 1'b1;
                        reqReadyR <= 1'b0;
                        state     <= SEND;
                    end
                end
                SEND: begin
                    if (xfer) begin
                        if (lastR) begin
                            validR    <= 1'b0;
                            lastR     <= 1'b0;
                            busyR     <= 1'b0;
                            dataR     <= '0;
                            seqR      <= seqR + 8'd1;
                            reqReadyR <= 1'b1;
                            state     <= IDLE;
                        end else begin
                            index <= nextIdx;
                            dataR <= nextWord;
                            lastR <= (nextIdx == 8'(LEN - 1));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/debug_snapshot_streamer.md
Name: debug_snapshot_streamer

Overview:
- Consumer end of the debug-register collection path: takes the aggregated debug outputs (last committed PC, active-list and store-queue occupancy, performance counters) and streams them to a host as framed 32-bit words.
- On a host request, captures an atomic snapshot in one cycle, then emits a fixed-length frame over a valid/ready stream.
- Sits outside the core, between the debug register output and the host/debug transport (UART bridge, JTAG mailbox).

Parameters:
- PC_WIDTH, 32, width of lastCommittedPC (1..32; zero-extended into word).
- AL_COUNT_WIDTH, 7, width of activeListCount (1..16).
- SQ_COUNT_WIDTH, 5, width of storeQueueCount (1..16).
- PERF_COUNTER_NUM, 4, number of 32-bit performance counters (1..250).

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- lastCommittedPC  in  PC_WIDTH  PC of last committed op.
- activeListCount  in  AL_COUNT_WIDTH  active-list occupancy.
- storeQueueCount  in  SQ_COUNT_WIDTH  store-queue occupancy.
- perfCounter  in  32*PERF_COUNTER_NUM  counters; counter i at bits [32i+31:32i].
- reqValid  in  1  host requests a snapshot.
- reqReady  out  1  request accepted when reqValid&&reqReady.
- outValid  out  1  frame word valid.
- outReady  in  1  host accepts word.
- outData  out  32  frame word.
- outLast  out  1  marks final word of frame.
- busy  out  1  frame in progress.

Behaviour:
- Interface: one clock (clk); rst asynchronous, active-high. All state clears immediately on rst assertion, regardless of clk.
- Reset values: reqReady=0 while rst asserted, 1 in the first cycle after release; outValid=0, outData=0, outLast=0, busy=0, seq=0, state=IDLE.
- FSM states:
  - IDLE: reqReady=1, outValid=0. On reqValid at the clock edge, latch all snapshot inputs, set index=0, go to SEND.
  - SEND: reqReady=0, busy=1, outValid=1, outData=word[index]. On outValid&&outReady: if outLast, go to IDLE and increment seq (8-bit, wraps 255->0); otherwise index++.
- Latency: outValid rises the cycle after request acceptance. Minimum frame duration is L cycles with outReady held high. The next request is accepted no earlier than the cycle after the last word transfers.
- Frame layout, L = 3+PERF_COUNTER_NUM words:
  - word0 header: {8'hD5, seq, L[7:0], 8'h00}, bits 31:24 first.
  - word1: lastCommittedPC zero-extended.
  - word2: {zero-ext storeQueueCount to 16b, zero-ext activeListCount to 16b}.
  - word3+i: perfCounter i.
- Snapshot is atomic: input changes after the capture edge never appear in the current frame.
- Stall: while outValid&&!outReady, outData and outLast hold stable; index does not advance.
- outLast=1 only on word L-1, with outValid=1.
- Requests while busy are not accepted (reqReady=0). The host holds reqValid and is served after the frame completes.
- rst mid-frame: frame is abandoned, outValid drops immediately, seq returns to 0, no partial completion.

Optional Feature:
- Macro: RSD_DEBUG_STREAM_CHECKSUM_EN.
- When defined:
  - Frame gains a trailing checksum word, the XOR of all preceding frame words (header included), so L = 4+PERF_COUNTER_NUM.
  - The header length field reflects this L.
  - outLast moves to the checksum word.
  - The checksum accumulates incrementally as words transfer and clears at each request acceptance.
- When undefined: no checksum word, L = 3+PERF_COUNTER_NUM, no accumulator logic.

Test Plan:
- Reset then single request, defaults (PERF_COUNTER_NUM=4, no checksum); PC=0x00001234, AL=5, SQ=3, counters 1,2,3,4; outReady=1 -> 7 words on consecutive cycles: 0xD5000700, 0x00001234, 0x00030005, 1, 2, 3, 4; outLast only on the 7th; busy high for 7 cycles.
- Backpressure: outReady toggled 1,0,0,1,... during a frame -> each word held stable across stall cycles; no word skipped or duplicated; total accepted words = 7.
- Atomicity: change PC to 0xDEADBEEF and counter0 to 99 one cycle after acceptance -> frame still carries 0x00001234 and 1.
- Back-to-back: reqValid held high through frame 1 -> second frame header 0xD5010700; reqReady low throughout frame 1; second acceptance one cycle after frame 1 outLast transfer.
- Async reset mid-frame at word 3 -> outValid=0 and busy=0 without a clock edge; next request header seq=0x00.
- With RSD_DEBUG_STREAM_CHECKSUM_EN and the first scenario's inputs -> header 0xD5000800; 8th word = XOR of the first 7 words; outLast on word 8.
